// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter (IC / DC).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   typedef enum logic {
      IC = 1'b0,
      DC = 1'b1
   } arb_owner_e;

   // Latched transaction fields are sized for the widest supported port.
   localparam int TXN_ADDR_W = 32;
   localparam int TXN_DATA_W = 32;

   typedef struct packed {
      logic [TXN_ADDR_W-1:0] addr;
      logic [TXN_DATA_W-1:0] wdata;
      logic                  we;
      logic                  byte_op;
   } mem_txn_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: both cache-side ports plus the memory port.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  ic_req_i;
   logic [ADDR_WIDTH-1:0] ic_address_i;
   logic                  ic_ready_o;
   logic [DATA_WIDTH-1:0] ic_read_data_o;

   logic                  dc_req_i;
   logic                  dc_write_enable_i;
   logic                  dc_byte_op_i;
   logic [ADDR_WIDTH-1:0] dc_address_i;
   logic [DATA_WIDTH-1:0] dc_write_data_i;
   logic                  dc_ready_o;
   logic [DATA_WIDTH-1:0] dc_read_data_o;

   logic                  mem_valid_o;
   logic                  mem_write_enable_o;
   logic                  mem_byte_op_o;
   logic [ADDR_WIDTH-1:0] mem_address_o;
   logic [DATA_WIDTH-1:0] mem_write_data_o;
   logic                  mem_ready_i;
   logic [DATA_WIDTH-1:0] mem_read_data_i;

   modport slave (
      input  ic_req_i, ic_address_i,
      input  dc_req_i, dc_write_enable_i, dc_byte_op_i, dc_address_i, dc_write_data_i,
      input  mem_ready_i, mem_read_data_i,
      output ic_ready_o, ic_read_data_o, dc_ready_o, dc_read_data_o,
      output mem_valid_o, mem_write_enable_o, mem_byte_op_o, mem_address_o, mem_write_data_o
   );

   modport master (
      output ic_req_i, ic_address_i,
      output dc_req_i, dc_write_enable_i, dc_byte_op_i, dc_address_i, dc_write_data_i,
      output mem_ready_i, mem_read_data_i,
      input  ic_ready_o, ic_read_data_o, dc_ready_o, dc_read_data_o,
      input  mem_valid_o, mem_write_enable_o, mem_byte_op_o, mem_address_o, mem_write_data_o
   );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select. MEM_ARB_ROUND_ROBIN_EN: ties alternate away from
// last_grant; otherwise DC always wins ties.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic       ic_req,
   input  logic       dc_req,
   input  arb_owner_e last_grant,
   output arb_owner_e winner
);
   arb_owner_e tie_winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign tie_winner = (last_grant == IC) ? DC : IC;
`else
   assign tie_winner = DC;
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      winner = IC;
      if (ic_req && dc_req) winner = tie_winner;
      else if (dc_req)      winner = DC;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences IC / DC requests onto the single memory port, one transaction at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see arb_pick).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   mem_port_arbiter_if.slave  bus
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_BUSY = BUSY;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]            state;
   arb_owner_e            owner;
   arb_owner_e            last_grant;
   arb_owner_e            winner;
   mem_txn_t              txn;
   logic [DATA_WIDTH-1:0] ic_rdata;
   logic [DATA_WIDTH-1:0] dc_rdata;

   arb_pick u_pick (
      .ic_req     (bus.ic_req_i),
      .dc_req     (bus.dc_req_i),
      .last_grant (last_grant),
      .winner     (winner)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         owner      <= IC;
         last_grant <= IC;
         txn        <= '0;
         ic_rdata   <= '0;
         dc_rdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.ic_req_i || bus.dc_req_i) begin
                  owner <= winner;
                  state <= S_BUSY;
                  if (winner == DC) begin
                     txn.addr    <= TXN_ADDR_W'(bus.dc_address_i);
                     txn.wdata   <= TXN_DATA_W'(bus.dc_write_data_i);
                     txn.we      <= bus.dc_write_enable_i;
                     txn.byte_op <= bus.dc_byte_op_i;
                  end else begin
                     txn.addr    <= TXN_ADDR_W'(bus.ic_address_i);
                     txn.wdata   <= '0;
                     txn.we      <= 1'b0;
                     txn.byte_op <= 1'b0;
                  end
               end
            end
            S_BUSY: begin
               // mem_ready_i is only honoured here; strays in other states are dropped.
               if (bus.mem_ready_i) begin
                  if (!txn.we) begin
                     if (owner == DC) dc_rdata <= bus.mem_read_data_i;
                     else             ic_rdata <= bus.mem_read_data_i;
                  end
                  last_grant <= owner;
                  state      <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Valid comes straight from state so an async reset drops it without a clock.
   assign bus.mem_valid_o        = (state == S_BUSY);
   assign bus.mem_write_enable_o = txn.we;
   assign bus.mem_byte_op_o      = txn.byte_op;
   assign bus.mem_address_o      = txn.addr[ADDR_WIDTH-1:0];
   assign bus.mem_write_data_o   = txn.wdata[DATA_WIDTH-1:0];

   assign bus.ic_ready_o     = (state == S_DONE) && (owner == IC);
   assign bus.dc_ready_o     = (state == S_DONE) && (owner == DC);
   assign bus.ic_read_data_o = ic_rdata;
   assign bus.dc_read_data_o = dc_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a latency-programmable
// memory responder, and a monitor checking every BUSY entry and ready pulse.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      arb_owner_e    side;
      logic [DW-1:0] ic_rd;
      logic [DW-1:0] dc_rd;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          we;
      logic          byte_op;
   } txe_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exp_t sb[$];
   txe_t txq[$];
   logic [DW-1:0] exp_ic = '0;
   logic [DW-1:0] exp_dc = '0;

   int            mem_lat    = 2;
   int            busy_cnt   = 0;
   logic          stray_rdy  = 1'b0;
   logic [DW-1:0] stray_data = '0;
   int            t_main;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] resp(input logic [AW-1:0] a);
      return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
   endfunction

   task automatic expect_txn(input arb_owner_e s, input logic we, input logic bo,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
      txq.push_back('{addr: a, wdata: wd, we: we, byte_op: bo});
      if (!we) begin
         if (s == IC) exp_ic = resp(a);
         else         exp_dc = resp(a);
      end
      sb.push_back('{side: s, ic_rd: exp_ic, dc_rd: exp_dc});
   endtask

   // Memory model: completes each BUSY after mem_lat cycles.
   always @(negedge clk_i) begin
      if (rst_ni && bus.mem_valid_o) begin
         busy_cnt++;
         if (busy_cnt == mem_lat) begin
            bus.mem_ready_i     = 1'b1;
            bus.mem_read_data_i = resp(bus.mem_address_o);
         end else begin
            bus.mem_ready_i     = 1'b0;
            bus.mem_read_data_i = '0;
         end
      end else begin
         busy_cnt            = 0;
         bus.mem_ready_i     = stray_rdy;
         bus.mem_read_data_i = stray_data;
      end
   end

   logic prev_valid = 1'b0;
   logic prev_rdy   = 1'b0;
   txe_t cur        = '{default: '0};
   exp_t e_m;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_valid = 1'b0;
         prev_rdy   = 1'b0;
         cur        = '{default: '0};
      end else begin
         if (bus.mem_valid_o && !prev_valid) begin
            if (txq.size() == 0) chk("unexpected_busy", 1, 0);
            else begin
               cur = txq.pop_front();
               chk("busy_txn", {bus.mem_address_o, bus.mem_write_data_o, bus.mem_write_enable_o, bus.mem_byte_op_o},
                   {cur.addr, cur.wdata, cur.we, cur.byte_op});
            end
         end else begin
            chk("mem_hold", {bus.mem_address_o, bus.mem_write_data_o, bus.mem_write_enable_o, bus.mem_byte_op_o},
                {cur.addr, cur.wdata, cur.we, cur.byte_op});
         end
         if (bus.ic_ready_o || bus.dc_ready_o) begin
            chk("ready_single_cycle", prev_rdy, 0);
            chk("ready_exclusive", bus.ic_ready_o & bus.dc_ready_o, 0);
            if (sb.size() == 0) chk("unexpected_ready", 1, 0);
            else begin
               e_m = sb.pop_front();
               chk("ready_side", bus.dc_ready_o, e_m.side == DC);
               chk("ic_read_data", bus.ic_read_data_o, e_m.ic_rd);
               chk("dc_read_data", bus.dc_read_data_o, e_m.dc_rd);
            end
         end
         prev_valid = bus.mem_valid_o;
         prev_rdy   = bus.ic_ready_o | bus.dc_ready_o;
      end
   end

   task automatic ic_run(input logic [AW-1:0] a, input int n, input int exp_lat);
      int t;
      for (int i = 0; i < n; i++) begin
         bus.ic_req_i     = 1'b1;
         bus.ic_address_i = a;
         t = 0;
         do begin @(negedge clk_i); t++; end while (!bus.ic_ready_o && t < 200);
         chk("ic_ready_seen", bus.ic_ready_o, 1);
         if (exp_lat > 0 && i == 0) chk("ic_latency", t, exp_lat);
      end
      bus.ic_req_i = 1'b0;
   endtask

   task automatic dc_run(input logic we, input logic bo, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int n, input int exp_lat);
      int t;
      for (int i = 0; i < n; i++) begin
         bus.dc_req_i          = 1'b1;
         bus.dc_write_enable_i = we;
         bus.dc_byte_op_i      = bo;
         bus.dc_address_i      = a;
         bus.dc_write_data_i   = wd;
         t = 0;
         do begin @(negedge clk_i); t++; end while (!bus.dc_ready_o && t < 200);
         chk("dc_ready_seen", bus.dc_ready_o, 1);
         if (exp_lat > 0 && i == 0) chk("dc_latency", t, exp_lat);
      end
      bus.dc_req_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, {bus.ic_ready_o, bus.dc_ready_o, bus.mem_valid_o, bus.mem_write_enable_o, bus.mem_byte_op_o}, 0);
      chk({tag, "_rdata"}, {bus.ic_read_data_o, bus.dc_read_data_o}, 0);
      chk({tag, "_mem"}, {bus.mem_address_o, bus.mem_write_data_o}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ic_req_i = 1'b0;  bus.ic_address_i = '0;
      bus.dc_req_i = 1'b0;  bus.dc_write_enable_i = 1'b0; bus.dc_byte_op_i = 1'b0;
      bus.dc_address_i = '0; bus.dc_write_data_i = '0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Single IC read, memory answers in the second BUSY cycle.
      expect_txn(IC, 1'b0, 1'b0, 32'h0000_0100, '0);
      ic_run(32'h0000_0100, 1, 3);
      @(negedge clk_i);

      // Back-to-back ties, last_grant is IC at this point.
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expect_txn(DC, 1'b0, 1'b0, 32'h0000_0600, '0);
      expect_txn(IC, 1'b0, 1'b0, 32'h0000_0500, '0);
      expect_txn(DC, 1'b0, 1'b0, 32'h0000_0600, '0);
      expect_txn(IC, 1'b0, 1'b0, 32'h0000_0500, '0);
      fork
         ic_run(32'h0000_0500, 2, 0);
         dc_run(1'b0, 1'b0, 32'h0000_0600, '0, 2, 0);
      join
`else
      expect_txn(DC, 1'b0, 1'b0, 32'h0000_0600, '0);
      expect_txn(DC, 1'b0, 1'b0, 32'h0000_0600, '0);
      expect_txn(DC, 1'b0, 1'b0, 32'h0000_0600, '0);
      expect_txn(IC, 1'b0, 1'b0, 32'h0000_0500, '0);
      fork
         ic_run(32'h0000_0500, 1, 0);
         dc_run(1'b0, 1'b0, 32'h0000_0600, '0, 3, 0);
      join
`endif
      @(negedge clk_i);

      // DC byte write: read-data registers must not move.
      expect_txn(DC, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_00AB);
      dc_run(1'b1, 1'b1, 32'h0000_0203, 32'h0000_00AB, 1, 3);
      @(negedge clk_i);

      // IC arrives while a slow DC write is BUSY.
      mem_lat = 4;
      expect_txn(DC, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_1234);
      expect_txn(IC, 1'b0, 1'b0, 32'h0000_0800, '0);
      fork
         dc_run(1'b1, 1'b0, 32'h0000_0700, 32'h0000_1234, 1, 5);
         begin
            repeat (2) @(negedge clk_i);
            ic_run(32'h0000_0800, 1, 0);
         end
      join
      mem_lat = 2;
      repeat (2) @(negedge clk_i);

      // Stray memory response while idle.
      stray_rdy  = 1'b1;
      stray_data = 32'hBAD0_BAD0;
      repeat (3) @(negedge clk_i);
      chk("stray_valid", bus.mem_valid_o, 0);
      stray_rdy = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("stray_rdata", {bus.ic_read_data_o, bus.dc_read_data_o}, {exp_ic, exp_dc});

      // Reset in the middle of a long IC read.
      mem_lat = 10;
      txq.push_back('{addr: 32'h0000_0900, wdata: '0, we: 1'b0, byte_op: 1'b0});
      bus.ic_req_i     = 1'b1;
      bus.ic_address_i = 32'h0000_0900;
      t_main = 0;
      do begin @(negedge clk_i); t_main++; end while (!bus.mem_valid_o && t_main < 50);
      chk("rst_busy_seen", bus.mem_valid_o, 1);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_valid", bus.mem_valid_o, 0);
      chk_all_zero("rst_mid");
      bus.ic_req_i = 1'b0;
      exp_ic  = '0;
      exp_dc  = '0;
      mem_lat = 2;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      expect_txn(IC, 1'b0, 1'b0, 32'h0000_0100, '0);
      ic_run(32'h0000_0100, 1, 3);

      t_main = 0;
      while (sb.size() != 0 && t_main < 50) begin @(negedge clk_i); t_main++; end
      repeat (2) @(negedge clk_i);
      chk("sb_drained", sb.size(), 0);
      chk("txq_drained", txq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single main-memory port between the instruction-fetch cache and the data cache (cacheline) of the core. Each requester raises a request, and the arbiter sequences it onto the memory port as one multi-cycle transaction. It then returns read data and a one-cycle ready pulse to the requester that was granted. It sits between both caches' memory interfaces and the memory model or bus.

## Interface
- `ADDR_WIDTH`, default 32: address width on all ports.
- `DATA_WIDTH`, default 32: data width on all ports.

- `clk_i`, input, 1: clock. All state is updated on the rising edge.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `ic_req_i`, input, 1: instruction-side read request. It is held until `ic_ready_o`.
- `ic_address_i`, input, ADDR_WIDTH: instruction-side address.
- `ic_ready_o`, output, 1: one-cycle completion pulse to the instruction side.
- `ic_read_data_o`, output, DATA_WIDTH: instruction-side read data.
- `dc_req_i`, input, 1: data-side request. It is held until `dc_ready_o`.
- `dc_write_enable_i`, input, 1: 1 means write, 0 means read.
- `dc_byte_op_i`, input, 1: byte access.
- `dc_address_i`, input, ADDR_WIDTH: data-side address.
- `dc_write_data_i`, input, DATA_WIDTH: data-side write data.
- `dc_ready_o`, output, 1: one-cycle completion pulse to the data side.
- `dc_read_data_o`, output, DATA_WIDTH: data-side read data.
- `mem_valid_o`, output, 1: a transaction is presented to memory.
- `mem_write_enable_o`, output, 1: memory write.
- `mem_byte_op_o`, output, 1: memory byte access.
- `mem_address_o`, output, ADDR_WIDTH: memory address.
- `mem_write_data_o`, output, DATA_WIDTH: memory write data.
- `mem_ready_i`, input, 1: memory completes the presented transaction in this cycle.
- `mem_read_data_i`, input, DATA_WIDTH: memory read data. It is valid when `mem_ready_i` is 1.

## Operation
- **FSM states:** IDLE, BUSY, DONE. The owner register is `owner ∈ {IC, DC}`, plus a `last_grant` register.
- **IDLE, no request:** the FSM stays in IDLE.
- **IDLE, any request:**
  - Pick the owner and latch its address, write data, write enable and byte-op into internal registers.
  - Move to BUSY.
  - For the IC owner, the latched write enable and byte-op are both 0.
- **BUSY:**
  - `mem_valid_o` = 1 and the `mem_*` outputs are driven from the latched registers. They are stable for the whole of BUSY.
  - When `mem_ready_i` = 1: capture `mem_read_data_i` into the owner's read-data register (reads only), set `last_grant` = owner, and move to DONE.
- **DONE:** the owner's `*_ready_o` = 1 for exactly this cycle, then the FSM moves to IDLE.
- **Read data:** the `*_read_data_o` registers hold their value until the next read completes for that side. Writes leave them unchanged.
- **Tie (both requests in IDLE):** the DC side wins, or the side selected by round-robin if `MEM_ARB_ROUND_ROBIN_EN` is defined (see Configuration).
- **Requester rules:**
  - A requester must deassert its request in the cycle after its ready pulse, unless it is issuing a new request.
  - A request seen in IDLE is always treated as new.
  - Requests arriving during BUSY or DONE wait; they are never dropped.
- **Stray memory response:** `mem_ready_i` outside BUSY is ignored.

## Timing
- **Reset values:**
  - FSM in IDLE, owner = IC, `last_grant` = IC.
  - All outputs are 0, including both read-data registers and the `mem_*` outputs.
- **Latency:**
  - A request is sampled in IDLE at cycle 0.
  - `mem_valid_o` rises at cycle 1.
  - If `mem_ready_i` arrives at cycle k (k ≥ 1), the ready pulse is at cycle k+1 and the FSM is back in IDLE at cycle k+2.
  - Minimum turnaround is 3 cycles per transaction.
- **Simultaneous events:**
  - A new request arriving in the same cycle that DONE completes is serviced from IDLE in the following cycle.
  - A request for the other side that is pending during DONE is granted at the next IDLE.
- **Reset mid-transaction:**
  - Asserting `rst_ni` low drops `mem_valid_o` immediately, without waiting for a clock edge.
  - The in-flight transaction is abandoned and no ready pulse is issued.
  - After reset, requesters must re-request.

## Configuration
- **`MEM_ARB_ROUND_ROBIN_EN` defined:** on a tie, the side ≠ `last_grant` wins. Because `last_grant` resets to IC, the first tie goes to DC.
- **Not defined:** fixed priority, DC always wins ties. `last_grant` is still maintained but is unused.

## Structure
- **Package `mem_arb_pkg`:**
  - Enum `arb_state_e` {IDLE, BUSY, DONE}.
  - Enum `arb_owner_e` {IC, DC}.
  - Packed struct `mem_txn_t` {addr, wdata, we, byte_op} for the latched transaction.
- **Sub-module `arb_pick`:** a combinational winner select taking `ic_req_i`, `dc_req_i` and `last_grant`, and producing `arb_owner_e`. It contains the macro-dependent logic.

## Test plan
- **Single IC read:**
  - Stimulus: `ic_req_i` with address 0x0000_0100; `mem_ready_i` in the second BUSY cycle with data 0xDEAD_BEEF.
  - Required response: `ic_ready_o` pulses once, `ic_read_data_o` = 0xDEAD_BEEF, `mem_write_enable_o` = 0 throughout.
- **DC byte write:**
  - Stimulus: address 0x0000_0203, data 0x0000_00AB.
  - Required response: during BUSY, `mem_valid_o`, `mem_write_enable_o` and `mem_byte_op_o` = 1 with the address and data held stable; `dc_ready_o` pulses; `dc_read_data_o` is unchanged.
- **Simultaneous requests, three back-to-back ties:**
  - With the macro: grant order DC, IC, DC.
  - Without the macro: DC, DC, DC, with IC starved until DC deasserts.
- **IC requests during a DC BUSY:**
  - Required response: IC is granted at the IDLE following DC's DONE.
  - `mem_address_o` switches only at the new BUSY.
- **Stray `mem_ready_i` in IDLE:**
  - Required response: no state change, no ready pulse, read-data registers unchanged.
- **`rst_ni` low mid-BUSY:**
  - Required response: `mem_valid_o` = 0 immediately; no ready pulse; all outputs 0.
  - A fresh IC request afterwards completes normally.
